// File: rtl/smpl_queue_if.sv
// Sample stream between the codec side and the queue, plus the burst stream
// the queue feeds to the filter bank.
interface smpl_queue_if;
  // wrt_smpl is a one-cycle valid strobe with no ready: the queue never
  // back-pressures, it buffers one pair during a burst and flags overrun on loss.
  // sequencing marks each valid burst output pair; the consumer must always accept.
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl_in;
  logic signed [15:0] rght_smpl_in;
  logic signed [15:0] lft_smpl_out;
  logic signed [15:0] rght_smpl_out;
  logic               sequencing;
  logic               overrun;

  modport master (
    output wrt_smpl, lft_smpl_in, rght_smpl_in,
    input  lft_smpl_out, rght_smpl_out, sequencing, overrun
  );

  modport slave (
    input  wrt_smpl, lft_smpl_in, rght_smpl_in,
    output lft_smpl_out, rght_smpl_out, sequencing, overrun
  );
endinterface

// File: rtl/smpl_queue.sv
// Circular stereo sample queue: after TAPS samples are held, each new write
// streams the TAPS most recent pairs (oldest first) to the FIR filter bank.
module smpl_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021,
  parameter int PTR_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  smpl_queue_if.slave bus
);

  localparam int CNT_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, RD_SETUP, READ} burst_e;

  burst_e             state, next_state;
  logic [PTR_W-1:0]   new_ptr, old_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt, rd_cnt;
  logic               pending;
  logic [15:0]        hold_l, hold_r;
  logic [15:0]        out_l, out_r;
  logic               seq_q, ovr_q;
  logic [15:0]        mem_l [DEPTH];
  logic [15:0]        mem_r [DEPTH];

  logic               busy, full, do_wr, start_burst;
  logic [15:0]        wr_l, wr_r;
  logic               rd_en, ld_rd, last_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A held pair always goes into memory before any newly arriving pair.
  assign busy        = (state != IDLE);
  assign full        = (cnt == CNT_W'(TAPS));
  assign do_wr       = !busy && (pending || bus.wrt_smpl);
  assign wr_l        = pending ? hold_l : bus.lft_smpl_in;
  assign wr_r        = pending ? hold_r : bus.rght_smpl_in;
  assign start_burst = do_wr && (cnt >= CNT_W'(TAPS - 1));

  // Burst FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Burst FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_burst) next_state = RD_SETUP;
      RD_SETUP: next_state = READ;
      READ:     if (last_rd) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Burst FSM: outputs
  always_comb begin
    rd_en   = (state == READ);
    ld_rd   = (state == RD_SETUP);
    last_rd = rd_en && (rd_cnt == CNT_W'(TAPS - 1));
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_l[new_ptr] <= wr_l;
      mem_r[new_ptr] <= wr_r;
    end
  end

  // Write pointers, fill count and the one-deep holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      old_ptr <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      hold_l  <= '0;
      hold_r  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (do_wr) begin
        new_ptr <= ptr_inc(new_ptr);
        if (full) old_ptr <= ptr_inc(old_ptr);
        else      cnt     <= cnt + CNT_W'(1);
      end
      if (busy) begin
        if (bus.wrt_smpl) begin
          if (pending) begin
            ovr_q <= 1'b1;
          end else begin
            hold_l  <= bus.lft_smpl_in;
            hold_r  <= bus.rght_smpl_in;
            pending <= 1'b1;
          end
        end
      end else if (pending) begin
        if (bus.wrt_smpl) begin
          hold_l <= bus.lft_smpl_in;
          hold_r <= bus.rght_smpl_in;
        end else begin
          pending <= 1'b0;
        end
      end
    end
  end

  // Read side: outputs hold their last value outside a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_cnt <= '0;
      out_l  <= '0;
      out_r  <= '0;
      seq_q  <= 1'b0;
    end else begin
      seq_q <= rd_en;
      if (ld_rd) begin
        rd_ptr <= old_ptr;
        rd_cnt <= '0;
      end else if (rd_en) begin
        out_l  <= mem_l[rd_ptr];
        out_r  <= mem_r[rd_ptr];
        rd_ptr <= ptr_inc(rd_ptr);
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.lft_smpl_out  = out_l;
  assign bus.rght_smpl_out = out_r;
  assign bus.sequencing    = seq_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_smpl_queue.sv
// Bench for smpl_queue: a small instance (DEPTH=8, TAPS=5) against a sample-history
// model, and a default-size instance for burst length and spacing.
module tb_smpl_queue;
  localparam int S_TAPS = 5;
  localparam int D_TAPS = 1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smpl_queue_if bus_s();
  smpl_queue_if bus_d();

  smpl_queue #(.DEPTH(8), .TAPS(5), .PTR_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  smpl_queue dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of accepted pairs, held pair and busy window
  logic [31:0] exp_q[$];
  int          exp_start_q[$];
  logic [31:0] hist_q[$];
  logic [31:0] pend_d;
  bit          pend_v   = 0;
  bit          ov_exp   = 0;
  int          busy_end = -1000;
  int          edge_n   = 0;

  function automatic void accept(input logic [31:0] d, input int e);
    hist_q.push_back(d);
    if (hist_q.size() > S_TAPS) void'(hist_q.pop_front());
    if (hist_q.size() == S_TAPS) begin
      foreach (hist_q[i]) exp_q.push_back(hist_q[i]);
      exp_start_q.push_back(e + 2);
      busy_end = e + 1 + S_TAPS;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_start_q.delete();
    hist_q.delete();
    pend_v   = 0;
    ov_exp   = 0;
    busy_end = -1000;
  endfunction

  always @(posedge clk) begin
    logic [31:0] d;
    edge_n++;
    if (rst_n) begin
      if (pend_v && edge_n == busy_end + 1) begin
        accept(pend_d, edge_n);
        pend_v = 0;
      end
      if (bus_s.wrt_smpl) begin
        d = {bus_s.lft_smpl_in, bus_s.rght_smpl_in};
        if (edge_n <= busy_end) begin
          if (pend_v) ov_exp = 1;
          else begin
            pend_d = d;
            pend_v = 1;
          end
        end else begin
          accept(d, edge_n);
        end
      end
    end
  end

  // Scoreboard on the small instance's burst stream
  int          run_len   = 0;
  int          burst_cnt = 0;
  bit          prev_seq  = 0;
  logic [31:0] last_burst[$];

  always @(negedge clk) begin
    logic [31:0] obs, e;
    int st;
    if (!rst_n) begin
      run_len  = 0;
      prev_seq = 0;
    end else begin
      if (bus_s.sequencing) begin
        if (!prev_seq) begin
          last_burst.delete();
          burst_cnt++;
          n_checks++;
          if (exp_start_q.size() == 0) begin
            n_fail++;
            $display("FAIL burst_start: burst at edge %0d, none expected", edge_n);
          end else begin
            st = exp_start_q.pop_front();
            if (edge_n !== st) begin
              n_fail++;
              $display("FAIL burst_start: got edge %0d, expected edge %0d", edge_n, st);
            end
          end
        end
        run_len++;
        obs = {bus_s.lft_smpl_out, bus_s.rght_smpl_out};
        last_burst.push_back(obs);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL burst_sample: got %h, none expected", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL burst_sample: got %h, expected %h", obs, e);
          end
        end
      end else if (prev_seq) begin
        n_checks++;
        if (run_len != S_TAPS) begin
          n_fail++;
          $display("FAIL burst_len: got %0d, expected %0d", run_len, S_TAPS);
        end
        run_len = 0;
      end
      prev_seq = bus_s.sequencing;
    end
  end

  task automatic put_s(input int l, input int r);
    @(negedge clk);
    bus_s.wrt_smpl     = 1'b1;
    bus_s.lft_smpl_in  = 16'(l);
    bus_s.rght_smpl_in = 16'(r);
    @(negedge clk);
    bus_s.wrt_smpl     = 1'b0;
  endtask

  task automatic put_d(input int n);
    @(negedge clk);
    bus_d.wrt_smpl     = 1'b1;
    bus_d.lft_smpl_in  = 16'(n);
    bus_d.rght_smpl_in = ~16'(n);
    @(negedge clk);
    bus_d.wrt_smpl     = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus_s.wrt_smpl = 0; bus_s.lft_smpl_in = 0; bus_s.rght_smpl_in = 0;
    bus_d.wrt_smpl = 0; bus_d.lft_smpl_in = 0; bus_d.rght_smpl_in = 0;
    rst_n = 1'b0;
    wait_cycles(3);
    n_checks += 5;
    if (bus_s.sequencing !== 1'b0) begin n_fail++; $display("FAIL reset_seq: got %b, expected 0", bus_s.sequencing); end
    if (bus_s.lft_smpl_out !== 16'sd0) begin n_fail++; $display("FAIL reset_lft: got %h, expected 0", bus_s.lft_smpl_out); end
    if (bus_s.rght_smpl_out !== 16'sd0) begin n_fail++; $display("FAIL reset_rght: got %h, expected 0", bus_s.rght_smpl_out); end
    if (bus_s.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b, expected 0", bus_s.overrun); end
    if (bus_d.sequencing !== 1'b0) begin n_fail++; $display("FAIL reset_seq_d: got %b, expected 0", bus_d.sequencing); end
    model_reset();
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_fill();
    for (int n = 1; n <= 4; n++) begin
      put_s(n, -n);
      wait_cycles(3);
    end
    n_checks++;
    if (burst_cnt !== 0) begin n_fail++; $display("FAIL fill_no_burst: got %0d bursts, expected 0", burst_cnt); end
    put_s(5, -5);
    wait_cycles(10);
    n_checks++;
    if (burst_cnt !== 1) begin n_fail++; $display("FAIL fill_burst: got %0d bursts, expected 1", burst_cnt); end
    for (int k = 0; k < 5; k++) begin
      logic [31:0] want;
      want = {16'(k + 1), 16'(-(k + 1))};
      n_checks++;
      if (k >= last_burst.size() || last_burst[k] !== want) begin
        n_fail++;
        $display("FAIL fill_data[%0d]: got %h, expected %h", k, (k < last_burst.size()) ? last_burst[k] : 32'hx, want);
      end
    end
  endtask

  task automatic test_steady();
    for (int n = 6; n <= 9; n++) begin
      put_s(n, -n);
      wait_cycles(10);
    end
    n_checks++;
    if (burst_cnt !== 5) begin n_fail++; $display("FAIL steady_bursts: got %0d, expected 5", burst_cnt); end
    for (int k = 0; k < 5; k++) begin
      logic [31:0] want;
      want = {16'(k + 5), 16'(-(k + 5))};
      n_checks++;
      if (k >= last_burst.size() || last_burst[k] !== want) begin
        n_fail++;
        $display("FAIL wrap_data[%0d]: got %h, expected %h", k, (k < last_burst.size()) ? last_burst[k] : 32'hx, want);
      end
    end
  endtask

  task automatic test_write_during_burst();
    int b0;
    b0 = burst_cnt;
    put_s(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    wait_cycles(2);
    put_s(10, -10);
    wait_cycles(20);
    n_checks += 3;
    if (burst_cnt !== b0 + 2) begin n_fail++; $display("FAIL wdb_bursts: got %0d, expected %0d", burst_cnt, b0 + 2); end
    if (bus_s.overrun !== 1'b0) begin n_fail++; $display("FAIL wdb_ovr: got %b, expected 0", bus_s.overrun); end
    if (last_burst.size() != 5 || last_burst[4][31:16] !== 16'd10) begin
      n_fail++; $display("FAIL wdb_last: last burst tail not sample 10 (size %0d)", last_burst.size());
    end
  endtask

  task automatic test_overrun();
    put_s(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    wait_cycles(1);
    put_s(11, -11);
    put_s(12, -12);
    wait_cycles(20);
    n_checks += 2;
    if (bus_s.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, expected 1", bus_s.overrun); end
    if (last_burst.size() != 5 || last_burst[4] !== {16'd11, 16'(-11)}) begin
      n_fail++; $display("FAIL ovr_last: last burst tail not sample 11 (size %0d)", last_burst.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int b0;
    put_s(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    wait_cycles(4);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus_s.sequencing !== 1'b0) begin n_fail++; $display("FAIL rmb_seq: got %b, expected 0", bus_s.sequencing); end
    if (bus_s.lft_smpl_out !== 16'sd0) begin n_fail++; $display("FAIL rmb_lft: got %h, expected 0", bus_s.lft_smpl_out); end
    if (bus_s.rght_smpl_out !== 16'sd0) begin n_fail++; $display("FAIL rmb_rght: got %h, expected 0", bus_s.rght_smpl_out); end
    if (bus_s.overrun !== 1'b0) begin n_fail++; $display("FAIL rmb_ovr: got %b, expected 0", bus_s.overrun); end
    model_reset();
    wait_cycles(2);
    rst_n = 1'b1;
    b0 = burst_cnt;
    for (int n = 0; n < 4; n++) begin
      put_s(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      wait_cycles(3);
    end
    n_checks++;
    if (burst_cnt !== b0) begin n_fail++; $display("FAIL rmb_refill: got %0d bursts, expected %0d", burst_cnt, b0); end
    put_s(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    wait_cycles(10);
    n_checks++;
    if (burst_cnt !== b0 + 1) begin n_fail++; $display("FAIL rmb_fifth: got %0d bursts, expected %0d", burst_cnt, b0 + 1); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus_s.wrt_smpl     = ($urandom_range(0, 3) == 0);
      bus_s.lft_smpl_in  = 16'($urandom_range(0, 65535));
      bus_s.rght_smpl_in = 16'($urandom_range(0, 65535));
    end
    @(negedge clk);
    bus_s.wrt_smpl = 1'b0;
    wait_cycles(20);
    n_checks++;
    if (bus_s.overrun !== ov_exp) begin n_fail++; $display("FAIL b2b_ovr: got %b, expected %b", bus_s.overrun, ov_exp); end
  endtask

  task automatic test_long_burst();
    int len1 = 0, len2 = 0, gap = 0;
    logic [15:0] first1 = 'x, first2 = 'x, last2 = 'x;
    for (int n = 1; n <= D_TAPS; n++) put_d(n);
    for (int c = 0; c < 1098; c++) begin
      @(negedge clk);
      if (bus_d.sequencing) begin
        if (len1 == 0) first1 = bus_d.lft_smpl_out;
        len1++;
      end else if (len1 > 0) gap++;
    end
    put_d(D_TAPS + 1);
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (bus_d.sequencing) begin
        if (len2 == 0) first2 = bus_d.lft_smpl_out;
        last2 = bus_d.lft_smpl_out;
        len2++;
      end else if (len2 == 0) gap++;
    end
    n_checks += 6;
    if (len1 != D_TAPS) begin n_fail++; $display("FAIL long_len1: got %0d, expected %0d", len1, D_TAPS); end
    if (len2 != D_TAPS) begin n_fail++; $display("FAIL long_len2: got %0d, expected %0d", len2, D_TAPS); end
    if (first1 !== 16'd1) begin n_fail++; $display("FAIL long_first1: got %h, expected 1", first1); end
    if (first2 !== 16'd2) begin n_fail++; $display("FAIL long_first2: got %h, expected 2", first2); end
    if (last2 !== 16'(D_TAPS + 1)) begin n_fail++; $display("FAIL long_last2: got %h, expected %h", last2, 16'(D_TAPS + 1)); end
    if (gap < 1) begin n_fail++; $display("FAIL long_gap: got %0d low cycles, expected at least 1", gap); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_write_during_burst();
    test_overrun();
    test_reset_mid_burst();
    test_back_to_back();
    test_long_burst();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected samples never streamed, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
